// File: rtl/test_pattern_sequencer_pkg.sv
// Shared constants and state encoding for the test pattern sequencer.
package test_pattern_sequencer_pkg;

    localparam int unsigned PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0] PATTERN_OFF = 4'd0;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage : test_pattern_sequencer_pkg

// File: rtl/test_pattern_sequencer.sv
// Selects the active VGA test pattern: manual next/prev stepping, timed auto-advance,
// and a forced black interval of BLANK_FRAMES frames around every change.
module test_pattern_sequencer
    import test_pattern_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS       = 8,
    parameter int unsigned START_PATTERN      = 1,
    parameter int unsigned FRAMES_PER_PATTERN = 120,
    parameter int unsigned BLANK_FRAMES       = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_frame_strobe,
    input  logic       i_next,
    input  logic       i_prev,
    input  logic       i_auto_en,
    output logic [3:0] o_pattern,
    output logic       o_blanking,
    output logic       o_changed
);

    localparam int unsigned CNT_MAX    = (FRAMES_PER_PATTERN > BLANK_FRAMES) ?
                                         FRAMES_PER_PATTERN : BLANK_FRAMES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned SHOW_LAST  = FRAMES_PER_PATTERN - 1;
    localparam int unsigned BLANK_LAST = (BLANK_FRAMES == 0) ? 0 : BLANK_FRAMES - 1;

    state_t                 state, state_n;
    logic [PATTERN_W-1:0]   r_target, target_n;
    logic [CNT_W-1:0]       r_frame_cnt, cnt_n;
    logic [PATTERN_W-1:0]   pattern_n;
    logic                   blanking_n;
    logic                   changed_n;
    logic                   single_step;

    // Wrap-around step through 1..NUM_PATTERNS in either direction.
    function automatic logic [PATTERN_W-1:0] step_pattern(
        input logic [PATTERN_W-1:0] cur,
        input logic                 fwd
    );
        logic [PATTERN_W-1:0] res;
        if (fwd) begin
            res = (cur == PATTERN_W'(NUM_PATTERNS)) ? PATTERN_W'(1) : cur + PATTERN_W'(1);
        end else begin
            res = (cur == PATTERN_W'(1)) ? PATTERN_W'(NUM_PATTERNS) : cur - PATTERN_W'(1);
        end
        return res;
    endfunction

    // Simultaneous next and prev cancel each other.
    assign single_step = i_next ^ i_prev;

    // State register, target, frame counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_BLANK;
            r_target    <= PATTERN_W'(START_PATTERN);
            r_frame_cnt <= '0;
            o_pattern   <= PATTERN_OFF;
            o_blanking  <= 1'b1;
            o_changed   <= 1'b0;
        end else begin
            state       <= state_n;
            r_target    <= target_n;
            r_frame_cnt <= cnt_n;
            o_pattern   <= pattern_n;
            o_blanking  <= blanking_n;
            o_changed   <= changed_n;
        end
    end

    // Next-state, stepping and counter logic; manual step takes priority over auto.
    always_comb begin
        state_n  = state;
        target_n = r_target;
        cnt_n    = r_frame_cnt;

        case (state)
            ST_SHOW: begin
                if (single_step) begin
                    target_n = step_pattern(r_target, i_next);
                    cnt_n    = '0;
                    state_n  = ST_BLANK;
                end else if (i_auto_en && i_frame_strobe) begin
                    if (r_frame_cnt == CNT_W'(SHOW_LAST)) begin
                        target_n = step_pattern(r_target, 1'b1);
                        cnt_n    = '0;
                        state_n  = ST_BLANK;
                    end else begin
                        cnt_n = r_frame_cnt + CNT_W'(1);
                    end
                end else if (!i_auto_en) begin
                    cnt_n = '0;
                end
            end
            ST_BLANK: begin
                if (single_step) begin
                    target_n = step_pattern(r_target, i_next);
                    cnt_n    = '0;
                end else if (BLANK_FRAMES == 0) begin
                    cnt_n   = '0;
                    state_n = ST_SHOW;
                end else if (i_frame_strobe) begin
                    if (r_frame_cnt == CNT_W'(BLANK_LAST)) begin
                        cnt_n   = '0;
                        state_n = ST_SHOW;
                    end else begin
                        cnt_n = r_frame_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = '0;
            end
        endcase

        pattern_n  = (state_n == ST_SHOW) ? target_n : PATTERN_OFF;
        blanking_n = (state_n == ST_BLANK);
        changed_n  = (state == ST_BLANK) && (state_n == ST_SHOW);
    end

endmodule : test_pattern_sequencer

// File: tb/tb_test_pattern_sequencer.sv
// Self-checking bench for test_pattern_sequencer with default parameters (8/1/120/2).
module tb_test_pattern_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_frame_strobe;
    logic       i_next;
    logic       i_prev;
    logic       i_auto_en;
    logic [3:0] o_pattern;
    logic       o_blanking;
    logic       o_changed;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       nxt;
        logic       prv;
        logic       stb;
        logic [3:0] pat;
        logic       blk;
        logic       chg;
        string      name;
    } vec_t;

    vec_t vecs[18];

    test_pattern_sequencer dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_frame_strobe (i_frame_strobe),
        .i_next         (i_next),
        .i_prev         (i_prev),
        .i_auto_en      (i_auto_en),
        .o_pattern      (o_pattern),
        .o_blanking     (o_blanking),
        .o_changed      (o_changed)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [3:0] pat, input logic blk,
                         input logic chg);
        n_cmp++;
        if (o_pattern !== pat || o_blanking !== blk || o_changed !== chg) begin
            n_err++;
            $display("FAIL %s: got pattern=%0d blanking=%b changed=%b, want pattern=%0d blanking=%b changed=%b",
                     name, o_pattern, o_blanking, o_changed, pat, blk, chg);
        end
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after the edge.
    task automatic drive(input logic nxt, input logic prv, input logic stb);
        i_next         = nxt;
        i_prev         = prv;
        i_frame_strobe = stb;
        @(posedge i_clk);
        #1;
        i_next         = 1'b0;
        i_prev         = 1'b0;
        i_frame_strobe = 1'b0;
    endtask

    // Issue n strobes separated by idle cycles; flag any change away from pat.
    task automatic strobes_hold(input int n, input logic [3:0] pat, input string name);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (o_pattern !== pat || o_blanking !== 1'b0) bad = 1'b1;
            drive(1'b0, 1'b0, 1'b0);
            if (o_pattern !== pat || o_blanking !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: pattern left %0d during %0d strobes (now %0d)", name, pat, n, o_pattern);
        end
        check({name, "_end"}, pat, 1'b0, 1'b0);
    endtask

    initial begin
        // Vectors from reset: BLANK, target 1, auto disabled.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "blank_idle"};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, "blank_strobe1"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "blank_idle2"};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, "show_start"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, "changed_one_cycle"};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "prev_wrap_blank"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, "prev_blank_s1"};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b1, "prev_wrap_to_8"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "next_wrap_blank"};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, "next_blank_s1"};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1, "next_wrap_to_1"};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, "both_ignored"};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "next_to_2"};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, "blank_s1_before_restart"};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, "next_in_blank"};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, "restart_s1"};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, "restart_show_3"};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, "show_3_idle"};

        i_rst          = 1'b1;
        i_frame_strobe = 1'b0;
        i_next         = 1'b0;
        i_prev         = 1'b0;
        i_auto_en      = 1'b0;
        #12;
        check("reset_state", 4'd0, 1'b1, 1'b0);
        #8;
        i_rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].nxt, vecs[i].prv, vecs[i].stb);
            check(vecs[i].name, vecs[i].pat, vecs[i].blk, vecs[i].chg);
        end

        // Auto-advance from pattern 3 on the 120th strobe.
        i_auto_en = 1'b1;
        strobes_hold(119, 4'd3, "auto_119");
        drive(1'b0, 1'b0, 1'b1);
        check("auto_120th", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("auto_blank_s1", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("auto_show_4", 4'd4, 1'b0, 1'b1);

        // Auto disabled: no change over 500 strobes.
        i_auto_en = 1'b0;
        strobes_hold(500, 4'd4, "auto_off_500");

        // Manual next coincident with the auto terminal strobe steps only once.
        i_auto_en = 1'b1;
        strobes_hold(119, 4'd4, "coinc_119");
        drive(1'b1, 1'b0, 1'b1);
        check("coinc_blank", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("coinc_blank_s1", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("coinc_show_5", 4'd5, 1'b0, 1'b1);
        i_auto_en = 1'b0;

        // Asynchronous reset while showing, between clock edges.
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_show", 4'd0, 1'b1, 1'b0);
        #1;
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        check("post_rst_s1", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("post_rst_show_1", 4'd1, 1'b0, 1'b1);

        // Asynchronous reset mid-BLANK with target 2 and one blank strobe counted.
        drive(1'b1, 1'b0, 1'b0);
        check("pre_rst_blank", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_blank", 4'd0, 1'b1, 1'b0);
        #1;
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        check("rst_blank_s1", 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check("rst_blank_show_start", 4'd1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_test_pattern_sequencer
